// File: rtl/vend_fsm_param_if.sv
// ============================================================================
// Module   : vend_fsm_param_if
// Brief    : Coin/cancel/acknowledge inputs and vend/change/credit outputs
//            of the vending controller, bundled with master/slave views.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface vend_fsm_param_if #(
    parameter int CREDIT_W = 5
);
    logic [2:0]          coin;
    logic                cancel;
    logic                vend_ack;
    logic                change_ack;
    logic                vend;
    logic [2:0]          change;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic [2:0]          state;

    modport master (
        output coin, cancel, vend_ack, change_ack,
        input  vend, change, coin_reject, credit, state
    );

    modport slave (
        input  coin, cancel, vend_ack, change_ack,
        output vend, change, coin_reject, credit, state
    );
endinterface

`default_nettype wire

// File: rtl/vend_fsm_param.sv
// ============================================================================
// Module   : vend_fsm_param
// Brief    : Parameterised vending controller: coin collection, vend
//            handshake and greedy coin-by-coin change / refund.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vend_fsm_param #(
    parameter int PRICE      = 5,
    parameter int MAX_CREDIT = 15,
    parameter int CREDIT_W   = 5
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    vend_fsm_param_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_COLLECT = 3'b001,
        S_VEND    = 3'b010,
        S_CHANGE  = 3'b011,
        S_REFUND  = 3'b100
    } state_t;

    localparam logic [CREDIT_W-1:0] c_PRICE   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   c_MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] c_ZERO    = '0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic                r_reject;
    logic                w_reject_nxt;

    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin_ok;
    logic                w_coin_any;
    logic                w_paying;
    logic [2:0]          w_chg_code;
    logic [CREDIT_W-1:0] w_chg_val;

    always_comb begin
        w_coin_val = c_ZERO;
        case (bus.coin)
            3'b001:  w_coin_val = CREDIT_W'(1);
            3'b010:  w_coin_val = CREDIT_W'(2);
            3'b101:  w_coin_val = CREDIT_W'(5);
            default: w_coin_val = c_ZERO;
        endcase
    end

    assign w_coin_any = (bus.coin != 3'b000);
    assign w_sum      = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_ok  = (w_coin_val != c_ZERO) && (w_sum <= c_MAX_SUM);
    assign w_paying   = (r_state == S_CHANGE) || (r_state == S_REFUND);

    // Greedy change coin, decoded purely from registered state and credit
    always_comb begin
        w_chg_code = 3'b000;
        w_chg_val  = c_ZERO;
        if (w_paying) begin
            if (r_credit >= CREDIT_W'(5)) begin
                w_chg_code = 3'b101;
                w_chg_val  = CREDIT_W'(5);
            end else if (r_credit >= CREDIT_W'(2)) begin
                w_chg_code = 3'b010;
                w_chg_val  = CREDIT_W'(2);
            end else begin
                w_chg_code = 3'b001;
                w_chg_val  = CREDIT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_reject_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_COLLECT: begin
                if ((r_state == S_COLLECT) && bus.cancel) begin
                    w_state_nxt  = S_REFUND;
                    w_reject_nxt = w_coin_any;
                end else if (w_coin_any) begin
                    if (w_coin_ok) begin
                        w_credit_nxt = w_sum[CREDIT_W-1:0];
                        w_state_nxt  = (w_sum[CREDIT_W-1:0] >= c_PRICE) ? S_VEND : S_COLLECT;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                end
            end
            S_VEND: begin
                w_reject_nxt = w_coin_any;
                if (bus.vend_ack) begin
                    if (r_credit > c_PRICE) begin
                        w_credit_nxt = r_credit - c_PRICE;
                        w_state_nxt  = S_CHANGE;
                    end else begin
                        w_credit_nxt = c_ZERO;
                        w_state_nxt  = S_IDLE;
                    end
                end
            end
            S_CHANGE, S_REFUND: begin
                w_reject_nxt = w_coin_any;
                if (bus.change_ack) begin
                    if (r_credit > w_chg_val) begin
                        w_credit_nxt = r_credit - w_chg_val;
                    end else begin
                        w_credit_nxt = c_ZERO;
                        w_state_nxt  = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_credit_nxt = c_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_credit <= c_ZERO;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_reject <= w_reject_nxt;
        end
    end

    assign bus.vend        = (r_state == S_VEND);
    assign bus.change      = w_chg_code;
    assign bus.coin_reject = r_reject;
    assign bus.credit      = r_credit;
    assign bus.state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_vend_fsm_param.sv
// ============================================================================
// Module   : tb_vend_fsm_param
// Brief    : Directed scoreboard bench for vend_fsm_param (default build and
//            a MAX_CREDIT=6 build).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vend_fsm_param;
    localparam int CW = 5;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_COLL = 3'd1, ST_VEND = 3'd2,
                           ST_CHG  = 3'd3, ST_REF  = 3'd4;
    localparam logic [2:0] C_NONE = 3'b000, C_NIC = 3'b001, C_DIME = 3'b010,
                           C_QTR  = 3'b101, C_BAD = 3'b011;

    logic clk;
    logic rst_n;

    vend_fsm_param_if #(.CREDIT_W(CW)) bus_a ();
    vend_fsm_param_if #(.CREDIT_W(CW)) bus_b ();

    vend_fsm_param #(.PRICE(5), .MAX_CREDIT(15), .CREDIT_W(CW)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    vend_fsm_param #(.PRICE(5), .MAX_CREDIT(6), .CREDIT_W(CW)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        bit           sel;
        logic [2:0]   st;
        logic [CW-1:0] cr;
        logic         vd;
        logic [2:0]   ch;
        logic         rj;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input string tag, input bit sel, input logic [2:0] st,
                        input int cr, input logic vd, input logic [2:0] ch,
                        input logic rj);
        exp_t e;
        e.tag = tag; e.sel = sel; e.st = st; e.cr = CW'(cr);
        e.vd = vd; e.ch = ch; e.rj = rj;
        sb.push_back(e);
    endtask

    task automatic check_front();
        exp_t          e;
        logic [2:0]    o_st;
        logic [CW-1:0] o_cr;
        logic          o_vd;
        logic [2:0]    o_ch;
        logic          o_rj;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: got size %0d want >0", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.sel) begin
                o_st = bus_b.state; o_cr = bus_b.credit; o_vd = bus_b.vend;
                o_ch = bus_b.change; o_rj = bus_b.coin_reject;
            end else begin
                o_st = bus_a.state; o_cr = bus_a.credit; o_vd = bus_a.vend;
                o_ch = bus_a.change; o_rj = bus_a.coin_reject;
            end
            checks += 4;
            assert (o_st === e.st) else begin
                errors++;
                $error("FAIL %s state: got %0d want %0d", e.tag, o_st, e.st);
            end
            assert (o_cr === e.cr) else begin
                errors++;
                $error("FAIL %s credit: got %0d want %0d", e.tag, o_cr, e.cr);
            end
            assert ((o_vd === e.vd) && (o_ch === e.ch)) else begin
                errors++;
                $error("FAIL %s vend/change: got %b/%b want %b/%b", e.tag, o_vd, o_ch, e.vd, e.ch);
            end
            assert (o_rj === e.rj) else begin
                errors++;
                $error("FAIL %s coin_reject: got %b want %b", e.tag, o_rj, e.rj);
            end
        end
    endtask

    // One clock of stimulus on the selected unit; expectation is for the
    // cycle after the sampling edge.
    task automatic cyc(input string tag, input bit sel, input logic [2:0] coin,
                       input logic cancel, input logic vack, input logic cack,
                       input logic [2:0] st, input int cr, input logic vd,
                       input logic [2:0] ch, input logic rj);
        if (sel) begin
            bus_b.coin = coin; bus_b.cancel = cancel;
            bus_b.vend_ack = vack; bus_b.change_ack = cack;
        end else begin
            bus_a.coin = coin; bus_a.cancel = cancel;
            bus_a.vend_ack = vack; bus_a.change_ack = cack;
        end
        push(tag, sel, st, cr, vd, ch, rj);
        @(posedge clk);
        #1;
        bus_a.coin = C_NONE; bus_a.cancel = 1'b0; bus_a.vend_ack = 1'b0; bus_a.change_ack = 1'b0;
        bus_b.coin = C_NONE; bus_b.cancel = 1'b0; bus_b.vend_ack = 1'b0; bus_b.change_ack = 1'b0;
        check_front();
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.coin = C_NONE; bus_a.cancel = 1'b0; bus_a.vend_ack = 1'b0; bus_a.change_ack = 1'b0;
        bus_b.coin = C_NONE; bus_b.cancel = 1'b0; bus_b.vend_ack = 1'b0; bus_b.change_ack = 1'b0;
        #3;
        push("reset_a", 1'b0, ST_IDLE, 0, 1'b0, C_NONE, 1'b0); check_front();
        push("reset_b", 1'b1, ST_IDLE, 0, 1'b0, C_NONE, 1'b0); check_front();
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single quarter buys the item exactly
        cyc("qtr",        0, C_QTR,  0, 0, 0, ST_VEND, 5, 1, C_NONE, 0);
        cyc("qtr_ack",    0, C_NONE, 0, 1, 0, ST_IDLE, 0, 0, C_NONE, 0);

        // Three dimes -> one nickel change
        cyc("d1",         0, C_DIME, 0, 0, 0, ST_COLL, 2, 0, C_NONE, 0);
        cyc("d2",         0, C_DIME, 0, 0, 0, ST_COLL, 4, 0, C_NONE, 0);
        cyc("d3",         0, C_DIME, 0, 0, 0, ST_VEND, 6, 1, C_NONE, 0);
        cyc("d3_vack",    0, C_NONE, 0, 1, 0, ST_CHG,  1, 0, C_NIC,  0);
        cyc("d3_cack",    0, C_NONE, 0, 0, 1, ST_IDLE, 0, 0, C_NONE, 0);

        // Dime, dime, quarter -> dime, dime change
        cyc("ddq1",       0, C_DIME, 0, 0, 0, ST_COLL, 2, 0, C_NONE, 0);
        cyc("ddq2",       0, C_DIME, 0, 0, 0, ST_COLL, 4, 0, C_NONE, 0);
        cyc("ddq3",       0, C_QTR,  0, 0, 0, ST_VEND, 9, 1, C_NONE, 0);
        cyc("ddq_vack",   0, C_NONE, 0, 1, 0, ST_CHG,  4, 0, C_DIME, 0);
        cyc("ddq_hold",   0, C_NONE, 0, 0, 0, ST_CHG,  4, 0, C_DIME, 0);
        cyc("ddq_cack1",  0, C_NONE, 0, 0, 1, ST_CHG,  2, 0, C_DIME, 0);
        cyc("ddq_cack2",  0, C_NONE, 0, 0, 1, ST_IDLE, 0, 0, C_NONE, 0);

        // Cancel beats a simultaneous coin
        cyc("can_nic",    0, C_NIC,  0, 0, 0, ST_COLL, 1, 0, C_NONE, 0);
        cyc("can_dime",   0, C_DIME, 1, 0, 0, ST_REF,  1, 0, C_NIC,  1);
        cyc("can_pulse",  0, C_NONE, 0, 0, 0, ST_REF,  1, 0, C_NIC,  0);
        cyc("can_cack",   0, C_NONE, 0, 0, 1, ST_IDLE, 0, 0, C_NONE, 0);

        // Ignored inputs in IDLE, invalid code, coins/cancel during VEND
        cyc("idle_cancel",0, C_NONE, 1, 1, 1, ST_IDLE, 0, 0, C_NONE, 0);
        cyc("idle_bad",   0, C_BAD,  0, 0, 0, ST_IDLE, 0, 0, C_NONE, 1);
        cyc("v_qtr",      0, C_QTR,  0, 0, 0, ST_VEND, 5, 1, C_NONE, 0);
        cyc("v_coin",     0, C_NIC,  0, 0, 1, ST_VEND, 5, 1, C_NONE, 1);
        cyc("v_cancel",   0, C_NONE, 1, 0, 0, ST_VEND, 5, 1, C_NONE, 0);
        cyc("v_ack",      0, C_NONE, 0, 1, 0, ST_IDLE, 0, 0, C_NONE, 0);

        // MAX_CREDIT=6 build: overflow and invalid coins rejected
        cyc("b_d1",       1, C_DIME, 0, 0, 0, ST_COLL, 2, 0, C_NONE, 0);
        cyc("b_d2",       1, C_DIME, 0, 0, 0, ST_COLL, 4, 0, C_NONE, 0);
        cyc("b_ovf",      1, C_QTR,  0, 0, 0, ST_COLL, 4, 0, C_NONE, 1);
        cyc("b_ovf_end",  1, C_NONE, 0, 0, 0, ST_COLL, 4, 0, C_NONE, 0);
        cyc("b_bad",      1, C_BAD,  0, 0, 0, ST_COLL, 4, 0, C_NONE, 1);
        cyc("b_max",      1, C_DIME, 0, 0, 0, ST_VEND, 6, 1, C_NONE, 0);
        cyc("b_vack",     1, C_NONE, 0, 1, 0, ST_CHG,  1, 0, C_NIC,  0);
        cyc("b_cack",     1, C_NONE, 0, 0, 1, ST_IDLE, 0, 0, C_NONE, 0);

        // Asynchronous reset while paying out a dime
        cyc("r_d1",       0, C_DIME, 0, 0, 0, ST_COLL, 2, 0, C_NONE, 0);
        cyc("r_d2",       0, C_DIME, 0, 0, 0, ST_COLL, 4, 0, C_NONE, 0);
        cyc("r_q",        0, C_QTR,  0, 0, 0, ST_VEND, 9, 1, C_NONE, 0);
        cyc("r_vack",     0, C_NONE, 0, 1, 0, ST_CHG,  4, 0, C_DIME, 0);
        #2 rst_n = 1'b0;
        #1;
        push("r_async", 0, ST_IDLE, 0, 1'b0, C_NONE, 1'b0); check_front();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        push("r_after", 0, ST_IDLE, 0, 1'b0, C_NONE, 1'b0); check_front();
        cyc("r_nic",      0, C_NIC,  0, 0, 0, ST_COLL, 1, 0, C_NONE, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish want finish before 20000");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
